alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares one combinational 8-bit ALU instance between NUM_REQ requesters. Arbitrates requests round-robin, drives the winner's operands and opcode into the ALU from registers, captures the ALU outputs one cycle later, and returns a tagged response on a single shared response channel. It sits between command sources (sequencers, test masters) and the ALU datapath, so the ALU itself stays purely combinational.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 3: width of rsp_id; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept.
- req_a  in  8*NUM_REQ  operand A, requester i at [8i+7:8i].
- req_b  in  8*NUM_REQ  operand B, same packing as req_a.
- req_sel  in  4*NUM_REQ  ALU opcode, requester i at [4i+3:4i].
- alu_a  out  8  registered operand A to the ALU.
- alu_b  out  8  registered operand B to the ALU.
- alu_sel  out  4  registered opcode to the ALU.
- alu_result  in  16  ALU result.
- alu_quotient  in  8  ALU quotient.
- alu_remainder  in  8  ALU remainder.
- alu_carry  in  1  ALU carry out.
- alu_div0  in  1  ALU divide-by-zero flag.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  16  captured result.
- rsp_quotient  out  8  captured quotient.
- rsp_remainder  out  8  captured remainder.
- rsp_carry  out  1  captured carry.
- rsp_err  out  1  captured div0, qualified by alu_sel==4'b0011; 0 for every other opcode.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any req_valid, assert req_ready to the winner in the same cycle. On that edge, register the winner's a/b/sel into alu_a/b/sel and its index into rsp_id, then go to EXEC.
- EXEC: the ALU settles. On the edge, capture all ALU outputs into the rsp_* registers, then go to RESP.
- RESP: rsp_valid=1. Hold every rsp_* output stable until rsp_ready; on that edge, go to IDLE.
- req_ready is all-zero outside IDLE and all-zero while rst_n is low.
- Requesters hold valid and payload stable until accepted. A valid dropped before ready is legal and ignored.
- Round-robin: priority pointer ptr, reset 0. Search order is ptr, ptr+1, … with wrap mod NUM_REQ. After a grant to i, ptr becomes (i+1) mod NUM_REQ.
- alu_a/b/sel keep the last issued values between transactions. They are not cleared.
- Opcodes are passed through unchecked. Unused codes (0110, 0111, 1011–1101) complete normally with whatever the ALU returns.

## Timing
- Reset values: req_ready 0, alu_a/b/sel 0, rsp_valid 0, rsp_id 0, rsp_result/quotient/remainder 0, rsp_carry 0, rsp_err 0, busy 0, ptr 0, state IDLE.
- Latency: accept edge T, capture T+1, rsp_valid high from T+2.
- Peak throughput: one transaction per 3 cycles (rsp_ready tied high). The next grant is in the cycle after the response handshake.
- Backpressure: rsp_ready low holds RESP indefinitely. No new requests are accepted meanwhile.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers keep valid and win in later rounds. No requester waits more than NUM_REQ-1 grants.
- Reset mid-transaction: any in-flight request and response is discarded. All outputs return to reset values asynchronously.

## Configuration
- ALU_ARB_FIXED_PRI_EN defined: fixed priority, lowest index wins. ptr is not implemented, and starvation of high indices is accepted.
- ALU_ARB_FIXED_PRI_EN undefined (default): round-robin as specified above.

## Structure
- Package alu_arb_pkg contains:
  - Opcode localparams: OP_ADD 0000, OP_SUB 0001, OP_MUL 0010, OP_DIV 0011, OP_SHL 0100, OP_SHR 0101, OP_AND 1000, OP_OR 1001, OP_XOR 1010, OP_GT 1110, OP_EQ 1111.
  - FSM state encoding.
  - Data widths (8/16).
- Sub-module alu_rr_arbiter: inputs req_valid and ptr (or fixed priority under the macro); outputs a one-hot grant and a binary index. Purely combinational.
- The ALU is instantiated outside this block and is not included.

## Test plan
- Single add: req0 a=20 b=15 sel=0000, rsp_ready=1 -> rsp_valid at T+2, rsp_id=0, rsp_result=35, rsp_err=0.
- Divide by zero: req1 a=40 b=0 sel=0011 -> rsp_err=1, rsp_id=1. A follow-up req1 a=40 b=5 sel=0011 -> rsp_quotient=8, rsp_remainder=0, rsp_err=0.
- All four requesters valid and held (add, sub 30-10, mul 7*6, and 0xAA&0xCC), reset ptr 0 -> rsp_id sequence 0,1,2,3 with results 35, 20, 42, 0x88. With ALU_ARB_FIXED_PRI_EN, req0 kept valid -> rsp_id always 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP with req2 valid -> rsp_* stable, req_ready all-zero. Release -> req2 granted the cycle after the handshake.
- Reset mid-EXEC: assert rst_n=0 one cycle after accept -> rsp_valid never rises, all outputs 0, and the transaction is not replayed after release.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the ALU arbiter: opcodes, data widths, FSM encoding.
package alu_arb_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;
    localparam int unsigned SEL_W  = 4;

    localparam logic [SEL_W-1:0] OP_ADD = 4'b0000;
    localparam logic [SEL_W-1:0] OP_SUB = 4'b0001;
    localparam logic [SEL_W-1:0] OP_MUL = 4'b0010;
    localparam logic [SEL_W-1:0] OP_DIV = 4'b0011;
    localparam logic [SEL_W-1:0] OP_SHL = 4'b0100;
    localparam logic [SEL_W-1:0] OP_SHR = 4'b0101;
    localparam logic [SEL_W-1:0] OP_AND = 4'b1000;
    localparam logic [SEL_W-1:0] OP_OR  = 4'b1001;
    localparam logic [SEL_W-1:0] OP_XOR = 4'b1010;
    localparam logic [SEL_W-1:0] OP_GT  = 4'b1110;
    localparam logic [SEL_W-1:0] OP_EQ  = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } alu_arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request and response channels between command sources and the ALU arbiter.
interface alu_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 3
) ();
    import alu_arb_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W*NUM_REQ-1:0] req_a;
    logic [DATA_W*NUM_REQ-1:0] req_b;
    logic [SEL_W*NUM_REQ-1:0]  req_sel;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [RES_W-1:0]          rsp_result;
    logic [DATA_W-1:0]         rsp_quotient;
    logic [DATA_W-1:0]         rsp_remainder;
    logic                      rsp_carry;
    logic                      rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_quotient, rsp_remainder,
               rsp_carry, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_quotient, rsp_remainder,
               rsp_carry, rsp_err
    );

endinterface

// File: rtl/alu_rr_arbiter.sv
// Combinational requester picker: round-robin from ptr, or lowest-index-wins when
// ALU_ARB_FIXED_PRI_EN is defined. Produces a one-hot grant and its binary index.
module alu_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 3
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx
);

    int unsigned base;
    int unsigned cand;
    logic        found;

`ifdef ALU_ARB_FIXED_PRI_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign base = 0;
`else
    assign base = 32'(ptr);
`endif

    // Scan from base upward with wrap; the first valid requester wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            cand = (base + off) % NUM_REQ;
            if (!found && req_valid[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: arbitrate, issue, capture, respond.
// Define ALU_ARB_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_arbiter_if.slave       bus,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SEL_W-1:0]   alu_sel,
    input  logic [RES_W-1:0]   alu_result,
    input  logic [DATA_W-1:0]  alu_quotient,
    input  logic [DATA_W-1:0]  alu_remainder,
    input  logic               alu_carry,
    input  logic               alu_div0,
    output logic               busy
);

    alu_arb_state_e state_q, state_d;

    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    ptr;
    logic               accept;
    logic               capture;

    logic [DATA_W-1:0]  win_a, win_b;
    logic [SEL_W-1:0]   win_sel;

    logic [DATA_W-1:0]  alu_a_q, alu_b_q;
    logic [SEL_W-1:0]   alu_sel_q;
    logic [ID_W-1:0]    rsp_id_q;
    logic [RES_W-1:0]   rsp_result_q;
    logic [DATA_W-1:0]  rsp_quotient_q, rsp_remainder_q;
    logic               rsp_carry_q, rsp_err_q;

    alu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid (bus.req_valid),
        .ptr       (ptr),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx)
    );

`ifdef ALU_ARB_FIXED_PRI_EN
    assign ptr = '0;
`else
    logic [ID_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`endif

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        win_a   = bus.req_a[32'(gnt_idx) * DATA_W +: DATA_W];
        win_b   = bus.req_b[32'(gnt_idx) * DATA_W +: DATA_W];
        win_sel = bus.req_sel[32'(gnt_idx) * SEL_W +: SEL_W];
    end

    // Operand registers are only loaded on accept, so they keep the last issued values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_sel_q       <= '0;
            rsp_id_q        <= '0;
            rsp_result_q    <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_carry_q     <= 1'b0;
            rsp_err_q       <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q   <= win_a;
                alu_b_q   <= win_b;
                alu_sel_q <= win_sel;
                rsp_id_q  <= gnt_idx;
            end
            if (capture) begin
                rsp_result_q    <= alu_result;
                rsp_quotient_q  <= alu_quotient;
                rsp_remainder_q <= alu_remainder;
                rsp_carry_q     <= alu_carry;
                rsp_err_q       <= alu_div0 && (alu_sel_q == OP_DIV);
            end
        end
    end

    // Gate with rst_n so no grant leaks out while reset holds the FSM in idle.
    assign bus.req_ready     = (state_q == StIdle && rst_n) ? gnt : '0;
    assign bus.rsp_valid     = (state_q == StResp);
    assign bus.rsp_id        = rsp_id_q;
    assign bus.rsp_result    = rsp_result_q;
    assign bus.rsp_quotient  = rsp_quotient_q;
    assign bus.rsp_remainder = rsp_remainder_q;
    assign bus.rsp_carry     = rsp_carry_q;
    assign bus.rsp_err       = rsp_err_q;

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;
    assign busy    = (state_q != StIdle);

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));

    a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
        bus.rsp_valid && !bus.rsp_ready |=> bus.rsp_valid &&
        $stable({bus.rsp_id, bus.rsp_result, bus.rsp_quotient, bus.rsp_remainder,
                 bus.rsp_carry, bus.rsp_err}));

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus a randomized run against
// a transaction-level model of arbitration order, latency and response contents.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  alu_a, alu_b, alu_quotient, alu_remainder;
    logic [3:0]  alu_sel;
    logic [15:0] alu_result;
    logic        alu_carry, alu_div0, busy;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [15:0] result;
        logic [7:0]  quotient;
        logic [7:0]  remainder;
        logic        carry;
        logic        div0;
    } alu_out_t;

    // Behavioural stand-in for the external ALU; div0 fires for any op so the
    // arbiter's opcode qualification is exercised.
    function automatic alu_out_t alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] sel);
        alu_out_t   o;
        logic [8:0] s;
        o = '0;
        o.div0      = (b == 8'd0);
        o.quotient  = (b == 8'd0) ? 8'hFF : a / b;
        o.remainder = (b == 8'd0) ? a : a % b;
        case (sel)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; o.result = {8'h00, s[7:0]}; o.carry = s[8]; end
            OP_SUB: begin s = {1'b0, a} - {1'b0, b}; o.result = {8'h00, s[7:0]}; o.carry = s[8]; end
            OP_MUL: o.result = {8'h00, a} * {8'h00, b};
            OP_DIV: o.result = {o.remainder, o.quotient};
            OP_SHL: o.result = {8'h00, a} << b[2:0];
            OP_SHR: o.result = {8'h00, a >> b[2:0]};
            OP_AND: o.result = {8'h00, a & b};
            OP_OR:  o.result = {8'h00, a | b};
            OP_XOR: o.result = {8'h00, a ^ b};
            OP_GT:  o.result = {15'd0, a > b};
            OP_EQ:  o.result = {15'd0, a == b};
            default: begin o.result = {b, a}; o.carry = ^a; end
        endcase
        return o;
    endfunction

    alu_out_t alu_now;
    assign alu_now       = alu_fn(alu_a, alu_b, alu_sel);
    assign alu_result    = alu_now.result;
    assign alu_quotient  = alu_now.quotient;
    assign alu_remainder = alu_now.remainder;
    assign alu_carry     = alu_now.carry;
    assign alu_div0      = alu_now.div0;

    alu_arbiter_if #(.NUM_REQ(NREQ), .ID_W(IDW)) bus ();

    alu_arbiter #(
        .NUM_REQ (NREQ),
        .ID_W    (IDW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_sel       (alu_sel),
        .alu_result    (alu_result),
        .alu_quotient  (alu_quotient),
        .alu_remainder (alu_remainder),
        .alu_carry     (alu_carry),
        .alu_div0      (alu_div0),
        .busy          (busy)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] sel);
        bus.req_valid[i]       = 1'b1;
        bus.req_a[i*8 +: 8]    = a;
        bus.req_b[i*8 +: 8]    = b;
        bus.req_sel[i*4 +: 4]  = sel;
    endtask

    task automatic wait_rsp(output bit ok);
        int n = 0;
        while (!bus.rsp_valid && n < 10) begin
            cyc();
            n++;
        end
        ok = bus.rsp_valid;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        bus.req_valid = '0;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.req_a = '1;
        bus.req_b = '1;
        bus.req_sel = '1;
        bus.rsp_ready = 1'b1;
        #12;
        tests_run++;
        if (bus.req_ready !== 4'b0000) begin
            tests_failed++;
            $display("FAIL rst_ready: got %b expected 0000", bus.req_ready);
        end
        tests_run++;
        if ({bus.rsp_valid, busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL rst_valid_busy: got %b expected 00", {bus.rsp_valid, busy});
        end
        tests_run++;
        if ({alu_a, alu_b, alu_sel} !== 20'd0) begin
            tests_failed++;
            $display("FAIL rst_alu_regs: got %h expected 0", {alu_a, alu_b, alu_sel});
        end
        tests_run++;
        if ({bus.rsp_id, bus.rsp_result, bus.rsp_quotient, bus.rsp_remainder,
             bus.rsp_carry, bus.rsp_err} !== 37'd0) begin
            tests_failed++;
            $display("FAIL rst_rsp_regs: got %h expected 0", {bus.rsp_id, bus.rsp_result,
                     bus.rsp_quotient, bus.rsp_remainder, bus.rsp_carry, bus.rsp_err});
        end
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_add();
        set_req(0, 8'd20, 8'd15, OP_ADD);
        bus.rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0001) begin
            tests_failed++;
            $display("FAIL add_grant: got %b expected 0001", bus.req_ready);
        end
        cyc();
        bus.req_valid[0] = 1'b0;
        tests_run++;
        if ({bus.rsp_valid, busy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL add_exec_state: got %b expected 01", {bus.rsp_valid, busy});
        end
        tests_run++;
        if ({alu_a, alu_b, alu_sel} !== {8'd20, 8'd15, OP_ADD}) begin
            tests_failed++;
            $display("FAIL add_issue: got %h expected %h", {alu_a, alu_b, alu_sel},
                     {8'd20, 8'd15, OP_ADD});
        end
        cyc();
        tests_run++;
        if (bus.rsp_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL add_latency: got rsp_valid=%b expected 1", bus.rsp_valid);
        end
        tests_run++;
        if ({bus.rsp_id, bus.rsp_result, bus.rsp_err} !== {3'd0, 16'd35, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_rsp: got id=%0d res=%0d err=%b expected id=0 res=35 err=0",
                     bus.rsp_id, bus.rsp_result, bus.rsp_err);
        end
        cyc();
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_back_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_div0();
        bit ok;
        set_req(1, 8'd40, 8'd0, OP_DIV);
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL div0_grant: got %b expected 0010", bus.req_ready);
        end
        cyc();
        bus.req_valid[1] = 1'b0;
        wait_rsp(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL div0_timeout: got no rsp_valid expected rsp_valid within bound");
        end
        tests_run++;
        if ({bus.rsp_id, bus.rsp_err} !== {3'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL div0_rsp: got id=%0d err=%b expected id=1 err=1",
                     bus.rsp_id, bus.rsp_err);
        end
        cyc();
        set_req(1, 8'd40, 8'd5, OP_DIV);
        #1;
        cyc();
        bus.req_valid[1] = 1'b0;
        wait_rsp(ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("FAIL div_timeout: got no rsp_valid expected rsp_valid within bound");
        end
        tests_run++;
        if ({bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_err} !==
            {3'd1, 8'd8, 8'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL div_rsp: got id=%0d q=%0d r=%0d err=%b expected id=1 q=8 r=0 err=0",
                     bus.rsp_id, bus.rsp_quotient, bus.rsp_remainder, bus.rsp_err);
        end
        cyc();
    endtask

    task automatic test_all_four();
        bit          ok;
        int          exp_id;
        logic [3:0]  oh;
        logic [15:0] exp_res [4];
        exp_res[0] = 16'd35;
        exp_res[1] = 16'd20;
        exp_res[2] = 16'd42;
        exp_res[3] = 16'h0088;
        reset_pulse();
        set_req(0, 8'd20, 8'd15, OP_ADD);
        set_req(1, 8'd30, 8'd10, OP_SUB);
        set_req(2, 8'd7, 8'd6, OP_MUL);
        set_req(3, 8'hAA, 8'hCC, OP_AND);
        bus.rsp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
            exp_id = 0;
`else
            exp_id = n;
`endif
            oh = '0;
            oh[exp_id] = 1'b1;
            #1;
            tests_run++;
            if (bus.req_ready !== oh) begin
                tests_failed++;
                $display("FAIL all4_grant[%0d]: got %b expected %b", n, bus.req_ready, oh);
            end
            cyc();
`ifndef ALU_ARB_FIXED_PRI_EN
            bus.req_valid[exp_id] = 1'b0;
`endif
            wait_rsp(ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("FAIL all4_timeout[%0d]: got no rsp_valid expected rsp_valid", n);
            end
            tests_run++;
            if ({bus.rsp_id, bus.rsp_result} !== {3'(exp_id), exp_res[exp_id]}) begin
                tests_failed++;
                $display("FAIL all4_rsp[%0d]: got id=%0d res=%h expected id=%0d res=%h", n,
                         bus.rsp_id, bus.rsp_result, exp_id, exp_res[exp_id]);
            end
            cyc();
        end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure();
        bit ok;
        set_req(0, 8'd20, 8'd15, OP_ADD);
        bus.rsp_ready = 1'b1;
        #1;
        cyc();
        bus.req_valid[0] = 1'b0;
        cyc();
        bus.rsp_ready = 1'b0;
        set_req(2, 8'd3, 8'd4, OP_XOR);
        #1;
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result} !== {1'b1, 3'd0, 16'd35}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d res=%0d expected v=1 id=0 res=35",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_result);
            end
            tests_run++;
            if (bus.req_ready !== 4'b0000) begin
                tests_failed++;
                $display("FAIL bp_no_grant[%0d]: got %b expected 0000", k, bus.req_ready);
            end
            cyc();
        end
        bus.rsp_ready = 1'b1;
        cyc();
        tests_run++;
        if (bus.req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL bp_grant_after: got %b expected 0100", bus.req_ready);
        end
        cyc();
        bus.req_valid[2] = 1'b0;
        wait_rsp(ok);
        tests_run++;
        if (!ok || {bus.rsp_id, bus.rsp_result} !== {3'd2, 16'd7}) begin
            tests_failed++;
            $display("FAIL bp_rsp: got v=%b id=%0d res=%0d expected v=1 id=2 res=7",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_result);
        end
        cyc();
    endtask

    task automatic test_reset_mid_exec();
        set_req(3, 8'h55, 8'hA3, OP_OR);
        bus.rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 4'b1000) begin
            tests_failed++;
            $display("FAIL rmid_grant: got %b expected 1000", bus.req_ready);
        end
        cyc();
        bus.req_valid[3] = 1'b0;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.rsp_valid, busy, bus.req_ready, alu_a, alu_b, alu_sel} !== 26'd0) begin
            tests_failed++;
            $display("FAIL rmid_async_clear: got %h expected 0",
                     {bus.rsp_valid, busy, bus.req_ready, alu_a, alu_b, alu_sel});
        end
        tests_run++;
        if ({bus.rsp_id, bus.rsp_result, bus.rsp_quotient, bus.rsp_remainder,
             bus.rsp_carry, bus.rsp_err} !== 37'd0) begin
            tests_failed++;
            $display("FAIL rmid_rsp_clear: got %h expected 0", {bus.rsp_id, bus.rsp_result,
                     bus.rsp_quotient, bus.rsp_remainder, bus.rsp_carry, bus.rsp_err});
        end
        cyc();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            tests_run++;
            if ({bus.rsp_valid, busy} !== 2'b00) begin
                tests_failed++;
                $display("FAIL rmid_no_replay[%0d]: got v/busy=%b expected 00", k,
                         {bus.rsp_valid, busy});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] pa [4];
        logic [7:0] pb [4];
        logic [3:0] ps [4];
        bit         pv [4];
        int         mptr, acc_cyc, exp_id, win, j;
        bit         outst, exp_valid;
        logic [7:0] ea, eb;
        logic [3:0] es;
        alu_out_t   er;
        logic [3:0] exp_ready;
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
            pb[i] = '0;
            ps[i] = '0;
        end
        reset_pulse();
        mptr = 0;
        outst = 1'b0;
        acc_cyc = 0;
        exp_id = 0;
        ea = '0;
        eb = '0;
        es = '0;
        er = '0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pv[i] && $urandom_range(3) == 0) begin
                    pv[i] = 1'b1;
                    pa[i] = 8'($urandom);
                    pb[i] = ($urandom_range(5) == 0) ? 8'd0 : 8'($urandom);
                    ps[i] = 4'($urandom);
                end else if (pv[i] && $urandom_range(15) == 0) begin
                    pv[i] = 1'b0;
                end
                bus.req_valid[i]      = pv[i];
                bus.req_a[i*8 +: 8]   = pa[i];
                bus.req_b[i*8 +: 8]   = pb[i];
                bus.req_sel[i*4 +: 4] = ps[i];
            end
            bus.rsp_ready = ($urandom_range(3) != 0);
            #1;
            win = -1;
            if (!outst) begin
                for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRI_EN
                    j = k;
`else
                    j = (mptr + k) % 4;
`endif
                    if (win < 0 && pv[j]) win = j;
                end
            end
            exp_ready = '0;
            if (win >= 0) exp_ready[win] = 1'b1;
            tests_run++;
            if (bus.req_ready !== exp_ready) begin
                tests_failed++;
                $display("FAIL rnd_grant c=%0d: got %b expected %b", c, bus.req_ready, exp_ready);
            end
            tests_run++;
            if (busy !== outst) begin
                tests_failed++;
                $display("FAIL rnd_busy c=%0d: got %b expected %b", c, busy, outst);
            end
            exp_valid = outst && (c - acc_cyc >= 2);
            tests_run++;
            if (bus.rsp_valid !== exp_valid) begin
                tests_failed++;
                $display("FAIL rnd_valid c=%0d: got %b expected %b", c, bus.rsp_valid, exp_valid);
            end
            if (outst) begin
                tests_run++;
                if ({alu_a, alu_b, alu_sel} !== {ea, eb, es}) begin
                    tests_failed++;
                    $display("FAIL rnd_issue c=%0d: got %h expected %h", c,
                             {alu_a, alu_b, alu_sel}, {ea, eb, es});
                end
            end
            if (exp_valid) begin
                tests_run++;
                if ({bus.rsp_id, bus.rsp_result, bus.rsp_quotient, bus.rsp_remainder,
                     bus.rsp_carry, bus.rsp_err} !==
                    {3'(exp_id), er.result, er.quotient, er.remainder, er.carry,
                     er.div0 && (es == OP_DIV)}) begin
                    tests_failed++;
                    $display("FAIL rnd_rsp c=%0d: got %h expected %h", c,
                             {bus.rsp_id, bus.rsp_result, bus.rsp_quotient,
                              bus.rsp_remainder, bus.rsp_carry, bus.rsp_err},
                             {3'(exp_id), er.result, er.quotient, er.remainder, er.carry,
                              er.div0 && (es == OP_DIV)});
                end
                if (bus.rsp_ready) outst = 1'b0;
            end
            if (win >= 0) begin
                outst   = 1'b1;
                acc_cyc = c;
                exp_id  = win;
                ea      = pa[win];
                eb      = pb[win];
                es      = ps[win];
                er      = alu_fn(ea, eb, es);
                pv[win] = 1'b0;
                mptr    = (win + 1) % 4;
            end
            cyc();
        end
        bus.req_valid = '0;
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_sel   = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_single_add();
        test_div0();
        test_all_four();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
